// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute/writeback sequencer for the
// 4-bit processor.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | nothing asserted, waits for run
//   FETCH     | imem_req high at address pc until imem_ready, loads ir, pc+1
//   DECODE    | one settle cycle for the external instruction decoder
//   EXECUTE   | drives ALU selects, updates z_flag/pc, flags illegal opcodes
//   WRITEBACK | one-cycle rf_we pulse, ALU selects held from EXECUTE
//   HALT      | halted high, left only through rst
module control_unit #(
   parameter int PC_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [7:0]      imem_rdata,
   output logic [7:0]      ir,
   input  logic [3:0]      dec_opcode,
   input  logic            dec_is_immediate,
   input  logic            alu_zero,
   output logic [2:0]      alu_op,
   output logic            alu_src_imm,
   output logic            rf_we,
   output logic [PC_W-1:0] pc,
   output logic            z_flag,
   output logic            halted,
   output logic            illegal
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_LOADI = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_XOR   = 4'b0110;
   localparam logic [3:0] OP_MOV   = 4'b0111;
   localparam logic [3:0] OP_JMP   = 4'b1000;
   localparam logic [3:0] OP_JZ    = 4'b1001;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_XOR  = 3'b101;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic            z_flag_q, z_flag_d;
   logic [2:0]      alu_op_q, alu_op_d;
   logic            alu_src_imm_q, alu_src_imm_d;

   logic [2:0]      exec_alu_op;
   logic            exec_src_imm;
   logic            exec_is_alu;
   logic            exec_writes_rf;
   logic [PC_W-1:0] jump_target;

   // Jump targets come straight from the low nibble of ir, zero-extended.
   assign jump_target = PC_W'(ir_q[3:0]);

   // Opcode classification: ALU select, operand source and register write.
   always_comb begin
      exec_alu_op    = ALU_PASS;
      exec_src_imm   = 1'b0;
      exec_is_alu    = 1'b0;
      exec_writes_rf = 1'b0;
      case (dec_opcode)
         OP_LOADI: begin
            exec_src_imm   = dec_is_immediate;
            exec_writes_rf = 1'b1;
         end
         OP_ADD: begin
            exec_alu_op    = ALU_ADD;
            exec_is_alu    = 1'b1;
            exec_writes_rf = 1'b1;
         end
         OP_SUB: begin
            exec_alu_op    = ALU_SUB;
            exec_is_alu    = 1'b1;
            exec_writes_rf = 1'b1;
         end
         OP_AND: begin
            exec_alu_op    = ALU_AND;
            exec_is_alu    = 1'b1;
            exec_writes_rf = 1'b1;
         end
         OP_OR: begin
            exec_alu_op    = ALU_OR;
            exec_is_alu    = 1'b1;
            exec_writes_rf = 1'b1;
         end
         OP_XOR: begin
            exec_alu_op    = ALU_XOR;
            exec_is_alu    = 1'b1;
            exec_writes_rf = 1'b1;
         end
         OP_MOV: begin
            exec_writes_rf = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Next-state, datapath register updates and per-state outputs.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      z_flag_d      = z_flag_q;
      alu_op_d      = alu_op_q;
      alu_src_imm_d = alu_src_imm_q;
      imem_req      = 1'b0;
      rf_we         = 1'b0;
      alu_op        = ALU_PASS;
      alu_src_imm   = 1'b0;
      halted        = 1'b0;
      illegal       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            alu_op        = exec_alu_op;
            alu_src_imm   = exec_src_imm;
            alu_op_d      = exec_alu_op;
            alu_src_imm_d = exec_src_imm;
            if (exec_is_alu) begin
               z_flag_d = alu_zero;
            end
            if (exec_writes_rf) begin
               state_d = ST_WRITEBACK;
            end else begin
               case (dec_opcode)
                  OP_NOP: state_d = ST_FETCH;
                  OP_JMP: begin
                     pc_d    = jump_target;
                     state_d = ST_FETCH;
                  end
                  OP_JZ: begin
                     if (z_flag_q) begin
                        pc_d = jump_target;
                     end
                     state_d = ST_FETCH;
                  end
                  OP_HALT: state_d = ST_HALT;
                  default: begin
                     // 1010..1110: flagged for one cycle, otherwise a NOP.
                     illegal = 1'b1;
                     state_d = ST_FETCH;
                  end
               endcase
            end
         end
         ST_WRITEBACK: begin
            rf_we       = 1'b1;
            alu_op      = alu_op_q;
            alu_src_imm = alu_src_imm_q;
            state_d     = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         ir_q          <= '0;
         z_flag_q      <= 1'b0;
         alu_op_q      <= ALU_PASS;
         alu_src_imm_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ir_q          <= ir_d;
         z_flag_q      <= z_flag_d;
         alu_op_q      <= alu_op_d;
         alu_src_imm_q <= alu_src_imm_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign z_flag    = z_flag_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a 16-entry instruction memory with a
// controllable ready line and a trivial decoder built from ir.
module tb_control_unit;

   localparam int PC_W = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            run;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ready;
   logic [7:0]      imem_rdata;
   logic [7:0]      ir;
   logic [3:0]      dec_opcode;
   logic            dec_is_immediate;
   logic            alu_zero;
   logic [2:0]      alu_op;
   logic            alu_src_imm;
   logic            rf_we;
   logic [PC_W-1:0] pc;
   logic            z_flag;
   logic            halted;
   logic            illegal;

   logic [7:0] mem [16];
   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_rdata       = mem[imem_addr];
   assign dec_opcode       = ir[7:4];
   assign dec_is_immediate = (ir[7:4] == 4'b0001);

   control_unit #(.PC_W(PC_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .run              (run),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ready       (imem_ready),
      .imem_rdata       (imem_rdata),
      .ir               (ir),
      .dec_opcode       (dec_opcode),
      .dec_is_immediate (dec_is_immediate),
      .alu_zero         (alu_zero),
      .alu_op           (alu_op),
      .alu_src_imm      (alu_src_imm),
      .rf_we            (rf_we),
      .pc               (pc),
      .z_flag           (z_flag),
      .halted           (halted),
      .illegal          (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock cycles; returns on a falling edge, away from the active edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   endtask

   // Two reset cycles; on return the DUT is in IDLE and run takes effect next edge.
   task automatic do_reset(input logic run_v);
      rst = 1'b1;
      run = 1'b0;
      tick(2);
      rst = 1'b0;
      run = run_v;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},     imem_req,    1'b0);
      chk({tag, "_rf_we"},   rf_we,       1'b0);
      chk({tag, "_alu_op"},  alu_op,      3'b000);
      chk({tag, "_src_imm"}, alu_src_imm, 1'b0);
      chk({tag, "_halted"},  halted,      1'b0);
      chk({tag, "_illegal"}, illegal,     1'b0);
      chk({tag, "_pc"},      pc,          4'h0);
      chk({tag, "_ir"},      ir,          8'h00);
      chk({tag, "_z"},       z_flag,      1'b0);
   endtask

   initial begin
      rst        = 1'b1;
      run        = 1'b0;
      imem_ready = 1'b1;
      alu_zero   = 1'b0;
      clear_mem();

      // ---- reset values; ready without req is ignored in IDLE ----
      do_reset(1'b0);
      chk_reset_outputs("rst");
      tick(2);
      chk("idle_no_req", imem_req, 1'b0);
      chk("idle_ir_hold", ir, 8'h00);

      // ---- LOADI r1,3 then HALT, zero-wait memory ----
      mem[0] = 8'h17;
      mem[1] = 8'hF0;
      do_reset(1'b1);
      tick(1);                                   // cycle 1: FETCH
      chk("ld_req_c1", imem_req, 1'b1);
      chk("ld_addr_c1", imem_addr, 4'h0);
      tick(1);                                   // cycle 2: DECODE
      chk("ld_ir", ir, 8'h17);
      chk("ld_pc", pc, 4'h1);
      chk("ld_req_dec", imem_req, 1'b0);
      chk("ld_we_c2", rf_we, 1'b0);
      tick(1);                                   // cycle 3: EXECUTE
      chk("ld_aluop_ex", alu_op, 3'b000);
      chk("ld_src_ex", alu_src_imm, 1'b1);
      chk("ld_we_c3", rf_we, 1'b0);
      tick(1);                                   // cycle 4: WRITEBACK
      chk("ld_we_c4", rf_we, 1'b1);
      chk("ld_src_wb", alu_src_imm, 1'b1);
      tick(1);                                   // cycle 5: FETCH addr 1
      chk("ld_we_c5", rf_we, 1'b0);
      chk("ld_next_addr", imem_addr, 4'h1);
      chk("ld_z_unchanged", z_flag, 1'b0);
      tick(2);                                   // EXECUTE of HALT
      chk("halt_not_yet", halted, 1'b0);
      tick(1);
      chk("halt_set", halted, 1'b1);
      tick(3);
      chk("halt_sticky", halted, 1'b1);
      chk("halt_no_req", imem_req, 1'b0);
      chk("halt_pc", pc, 4'h2);
      rst = 1'b1;
      tick(1);
      chk_reset_outputs("halt_rst");
      rst = 1'b0;
      tick(1);
      chk("halt_rst_refetch", imem_addr, 4'h0);
      chk("halt_rst_req", imem_req, 1'b1);

      // ---- ADD with alu_zero=1, then JZ 0xA: taken ----
      clear_mem();
      mem[0] = 8'h26;
      mem[1] = 8'h9A;
      alu_zero = 1'b1;
      do_reset(1'b1);
      tick(3);                                   // EXECUTE of ADD
      chk("add_aluop", alu_op, 3'b001);
      chk("add_src", alu_src_imm, 1'b0);
      tick(1);                                   // WRITEBACK
      chk("add_z_set", z_flag, 1'b1);
      chk("add_we", rf_we, 1'b1);
      chk("add_aluop_wb", alu_op, 3'b001);
      tick(1);                                   // FETCH JZ
      alu_zero = 1'b0;
      tick(2);                                   // EXECUTE of JZ
      chk("jz_we", rf_we, 1'b0);
      tick(1);                                   // FETCH at target
      chk("jz_taken_addr", imem_addr, 4'hA);
      chk("jz_z_kept", z_flag, 1'b1);

      // ---- same with alu_zero=0: JZ not taken ----
      alu_zero = 1'b0;
      do_reset(1'b1);
      tick(4);
      chk("add0_z", z_flag, 1'b0);
      tick(4);
      chk("jz_not_taken_addr", imem_addr, 4'h2);

      // ---- JMP 0xF then NOP at 0xF: pc wraps to 0 ----
      clear_mem();
      mem[0] = 8'h8F;
      do_reset(1'b1);
      tick(4);
      chk("jmp_addr", imem_addr, 4'hF);
      chk("jmp_req", imem_req, 1'b1);
      tick(3);
      chk("wrap_addr", imem_addr, 4'h0);
      chk("wrap_req", imem_req, 1'b1);

      // ---- imem_ready low for 3 cycles ----
      clear_mem();
      mem[0] = 8'h17;
      imem_ready = 1'b0;
      do_reset(1'b1);
      tick(1);
      chk("ws_req_c1", imem_req, 1'b1);
      tick(2);
      chk("ws_req_c3", imem_req, 1'b1);
      chk("ws_addr_c3", imem_addr, 4'h0);
      chk("ws_ir_c3", ir, 8'h00);
      tick(1);
      chk("ws_req_c4", imem_req, 1'b1);
      chk("ws_ir_c4", ir, 8'h00);
      chk("ws_pc_c4", pc, 4'h0);
      imem_ready = 1'b1;
      tick(1);
      chk("ws_ir_loaded", ir, 8'h17);
      chk("ws_req_dec", imem_req, 1'b0);
      tick(2);
      chk("ws_we", rf_we, 1'b1);

      // ---- ADD sets z, then illegal 0xC5 ----
      clear_mem();
      mem[0] = 8'h26;
      mem[1] = 8'hC5;
      alu_zero = 1'b1;
      do_reset(1'b1);
      tick(5);
      alu_zero = 1'b0;
      chk("il_pre", illegal, 1'b0);
      tick(2);                                   // EXECUTE of illegal
      chk("il_pulse", illegal, 1'b1);
      chk("il_we", rf_we, 1'b0);
      tick(1);
      chk("il_pulse_end", illegal, 1'b0);
      chk("il_we_after", rf_we, 1'b0);
      chk("il_pc", pc, 4'h2);
      chk("il_z_kept", z_flag, 1'b1);

      // ---- reset during DECODE of ADD ----
      clear_mem();
      mem[0] = 8'h26;
      do_reset(1'b1);
      tick(2);                                   // DECODE of ADD
      rst = 1'b1;
      tick(1);
      chk("ra_we", rf_we, 1'b0);
      chk("ra_pc", pc, 4'h0);
      chk("ra_ir", ir, 8'h00);
      tick(1);
      chk("ra_we2", rf_we, 1'b0);
      rst = 1'b0;
      run = 1'b0;
      tick(1);
      chk("ra_idle_req", imem_req, 1'b0);
      chk("ra_idle_we", rf_we, 1'b0);
      run = 1'b1;
      tick(1);
      chk("ra_refetch_req", imem_req, 1'b1);
      chk("ra_refetch_addr", imem_addr, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 4-bit processor. It fetches 8-bit instructions over a request/ready memory handshake, holds them in the instruction register that drives the instruction decoder, and steps each instruction through DECODE, EXECUTE and WRITEBACK. It issues ALU operation selects, the register-file write strobe, PC updates for jumps, and halt and illegal-opcode status. It sits between instruction memory, the instruction decoder, the ALU and the 4x4 register file.

## Interface
- PC_W, 4, program counter / instruction memory address width; jump targets are zero-extended to PC_W.

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; leaves IDLE when high
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  8  fetched instruction
- ir  out  8  instruction register, feeds decoder
- dec_opcode  in  4  decoder opcode (ir[7:4])
- dec_is_immediate  in  1  decoder immediate flag
- alu_zero  in  1  ALU result-is-zero
- alu_op  out  3  000 pass, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR
- alu_src_imm  out  1  ALU B operand = decoder imm_value
- rf_we  out  1  register-file write strobe (dest = reg_a_addr)
- pc  out  PC_W  program counter
- z_flag  out  1  zero flag
- halted  out  1  sticky halt status
- illegal  out  1  one-cycle illegal-opcode pulse

## Operation
- ISA opcodes:
  - 0000 NOP
  - 0001 LOADI (immediate)
  - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR
  - 0111 MOV (reg_b to reg_a)
  - 1000 JMP (target ir[3:0])
  - 1001 JZ (target ir[3:0], taken if z_flag=1)
  - 1111 HALT
  - 1010–1110 illegal
- States:
  - IDLE: no outputs asserted; goes to FETCH when run=1.
  - FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ready. On the req&&ready cycle: ir<=imem_rdata, pc<=pc+1 (wraps 2^PC_W-1 to 0), then DECODE.
  - DECODE: one cycle for the decoder to settle; goes to EXECUTE.
  - EXECUTE: drive alu_op and alu_src_imm.
    - ALU-class (ADD..XOR), LOADI, MOV: go to WRITEBACK. ALU-class also sets z_flag<=alu_zero.
    - JMP: pc<=ir[3:0]. JZ: same, only if z_flag=1. Both then FETCH.
    - NOP: FETCH.
    - Illegal: illegal=1 for this cycle, treated as NOP, then FETCH.
    - HALT: go to HALT.
  - WRITEBACK: rf_we=1 for exactly one cycle; alu_op and alu_src_imm held from EXECUTE; goes to FETCH.
  - HALT: halted=1; stays there until rst. run is ignored.
- Operand select rules:
  - LOADI: alu_op=000, alu_src_imm=1.
  - MOV: alu_op=000, alu_src_imm=0.
  - alu_src_imm mirrors dec_is_immediate for LOADI; 0 for all other opcodes.
- run is sampled only in IDLE. Dropping run mid-instruction has no effect.
- z_flag is unchanged by LOADI, MOV, jumps, NOP and illegal opcodes.

## Timing
- Reset values: state IDLE, pc=0, ir=0, z_flag=0, imem_req=0, rf_we=0, alu_op=000, alu_src_imm=0, halted=0, illegal=0.
- Reset mid-instruction (any state, including during an outstanding fetch) aborts it. rf_we is not asserted afterwards and the next fetch starts at address 0.
- Latency with zero-wait memory (imem_ready high in the first FETCH cycle):
  - register-writing instructions: 4 cycles
  - NOP, JMP, JZ, illegal: 3 cycles
  - HALT: 3 cycles to reach the HALT state
- Each cycle imem_ready is low adds one cycle in FETCH.
- imem_ready with imem_req low is ignored.
- rf_we asserts 3 cycles after the fetch-accept edge.
- The z_flag written by an instruction is visible to a JZ that immediately follows it.
- JMP/JZ to the instruction's own address loops forever, with no special handling.
- pc wrap at 2^PC_W-1 is silent.

## Test plan
- Reset, run=1, zero-wait memory with mem[0]=8'b0001_01_11 (LOADI r1,3) -> imem_req high at cycle 1; ir=0x17 after the accept; alu_op=000 and alu_src_imm=1 in EXECUTE; rf_we pulses exactly at cycle 4; pc=1.
- ADD (8'b0010_01_10) with alu_zero=1 in EXECUTE, followed by JZ to 4'hA -> z_flag=1, jump taken, next imem_addr=0xA. Repeat with alu_zero=0 -> next imem_addr=pc+1.
- imem_ready held low for 3 cycles -> imem_req and imem_addr stay stable; FETCH lasts 4 cycles; ir is not loaded early.
- Opcode 1100 -> illegal is a single-cycle pulse, rf_we stays 0, pc advances by 1, z_flag unchanged.
- HALT (0xF0) -> halted=1 after 3 cycles; no further imem_req while run stays 1; rst returns all outputs to reset values and pc=0.
- rst asserted during WRITEBACK-pending DECODE of an ADD -> rf_we never asserts; state is IDLE; a fetch with run=1 restarts at address 0.
